// File: rtl/query_scheduler.sv
// query_scheduler: upstream driver for the Collatz query engine.
// Seeds are buffered in a small FIFO; on a slot tick the head seed is issued
// to the engine as a one-cycle strobe, the engine's data stream is tracked
// until end-of-query or timeout, and the outcome is offered on a result port.
//
// Result handshake: oResultValid is high exactly while the FSM sits in REPORT,
// and all oResult* fields are held stable for that whole time. A result is
// transferred on a rising iClk edge where oResultValid && iResultReady; the
// FSM then leaves REPORT on that same edge. The seed port follows the same
// rule: a seed is taken on an edge where iSeedValid && oSeedReady.
module query_scheduler #(
    parameter int BW_QUERY_DATA  = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int BW_STEP        = 8,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int TICK_GATED     = 1,
    parameter int BW_MISS        = 8
) (
    input  logic                           iClk,
    input  logic                           iRsn,
    // seed push port
    input  logic                           iSeedValid,
    input  logic [BW_QUERY_DATA-1:0]       iSeed,
    output logic                           oSeedReady,
    output logic [$clog2(FIFO_DEPTH):0]    oFifoCount,
    // engine side
    input  logic                           iSlotTick,
    output logic                           oQueryDataEn,
    output logic [BW_QUERY_DATA-1:0]       oQueryData,
    input  logic [BW_QUERY_DATA-1:0]       iQueryData,
    input  logic                           iQueryEnd,
    // result port
    output logic                           oResultValid,
    input  logic                           iResultReady,
    output logic [BW_QUERY_DATA-1:0]       oResultSeed,
    output logic [BW_STEP-1:0]             oResultSteps,
    output logic [BW_QUERY_DATA-1:0]       oResultPeak,
    output logic                           oResultTimeout,
    // status
    output logic                           oBusy,
    output logic [BW_MISS-1:0]             oMissedTicks,
    // debug view of the FSM state (0 IDLE, 1 ISSUE, 2 RUN, 3 REPORT)
    output logic [1:0]                     oState
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]      FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [BW_STEP-1:0] TIMEOUT_VAL = BW_STEP'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } stateT;

    stateT state;
    stateT nextState;

    // Seed FIFO storage and bookkeeping
    logic [BW_QUERY_DATA-1:0] fifoMem [FIFO_DEPTH];
    logic [PW-1:0]            wrPtr;
    logic [PW-1:0]            rdPtr;
    logic [CW-1:0]            fifoCount;
    logic                     push;
    logic                     pop;

    // Query tracking registers
    logic [BW_QUERY_DATA-1:0] seedReg;
    logic [BW_STEP-1:0]       stepCnt;
    logic [BW_STEP-1:0]       stepInc;
    logic [BW_QUERY_DATA-1:0] peakReg;
    logic [BW_QUERY_DATA-1:0] newPeak;
    logic                     timeoutReg;
    logic [BW_MISS-1:0]       missCnt;

    logic                     issueAllowed;
    logic                     startQuery;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never turns a full FIFO into an accepting one.
    assign oSeedReady = (fifoCount != FULL_COUNT);
    assign oFifoCount = fifoCount;
    assign push       = iSeedValid && oSeedReady;
    assign pop        = startQuery;

    // With gating disabled the scheduler issues as soon as it is idle.
    assign issueAllowed = (TICK_GATED == 0) ? 1'b1 : iSlotTick;

    assign stepInc = stepCnt + BW_STEP'(1);
    assign newPeak = (iQueryData > peakReg) ? iQueryData : peakReg;

    // FIFO storage write; contents need no reset since count gates every read
    always_ff @(posedge iClk) begin
        if (push) begin
            fifoMem[wrPtr] <= iSeed;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CW'(1);
                2'b01:   fifoCount <= fifoCount - CW'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state logic; a tick with an empty FIFO is simply ignored
    always_comb begin
        nextState  = state;
        startQuery = 1'b0;
        case (state)
            IDLE: begin
                if ((fifoCount != '0) && issueAllowed) begin
                    nextState  = ISSUE;
                    startQuery = 1'b1;
                end
            end
            ISSUE: begin
                nextState = RUN;
            end
            RUN: begin
                if (iQueryEnd || (stepInc == TIMEOUT_VAL)) begin
                    nextState = REPORT;
                end
            end
            REPORT: begin
                if (iResultReady) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Query datapath: latch the head seed, then accumulate steps and peak.
    // End-of-query has priority over the timeout check in the same cycle.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            seedReg    <= '0;
            stepCnt    <= '0;
            peakReg    <= '0;
            timeoutReg <= 1'b0;
        end else begin
            if (startQuery) begin
                seedReg <= fifoMem[rdPtr];
            end
            case (state)
                ISSUE: begin
                    stepCnt    <= '0;
                    peakReg    <= '0;
                    timeoutReg <= 1'b0;
                end
                RUN: begin
                    peakReg <= newPeak;
                    if (iQueryEnd) begin
                        timeoutReg <= 1'b0;
                    end else begin
                        stepCnt    <= stepInc;
                        timeoutReg <= (stepInc == TIMEOUT_VAL);
                    end
                end
                default: begin
                    stepCnt    <= stepCnt;
                    peakReg    <= peakReg;
                    timeoutReg <= timeoutReg;
                end
            endcase
        end
    end

    // Missed-tick counter: ticks arriving while a query is in flight, saturating
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            missCnt <= '0;
        end else if (iSlotTick && (state != IDLE) && (missCnt != '1)) begin
            missCnt <= missCnt + BW_MISS'(1);
        end
    end

    // Outputs are decoded from the state register, so an asynchronous reset
    // clears the strobe and result-valid immediately.
    assign oQueryDataEn   = (state == ISSUE);
    assign oQueryData     = oQueryDataEn ? seedReg : '0;
    assign oResultValid   = (state == REPORT);
    assign oResultSeed    = seedReg;
    assign oResultSteps   = stepCnt;
    assign oResultPeak    = peakReg;
    assign oResultTimeout = timeoutReg;
    assign oBusy          = (state != IDLE);
    assign oMissedTicks   = missCnt;
    assign oState         = state;

endmodule
